serial_out_port: RTL and testbench

//  Serial output stage downstream of the 8-bit parallel output port register.

---
 rtl/serial_out_port.sv | 143 ++++++++++++++
 tb/tb_serial_out_port.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_out_port.sv
// Async serial transmitter: start bit 0, data LSB first, stop bit(s) 1, with a
// one-deep holding register so a second byte can be queued during a frame.
module serial_out_port #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic [DATA_BITS-1:0] iData,
  input  logic                 iStart,
  output logic                 oTx,
  output logic                 oBusy,
  output logic                 oReady,
  output logic                 oDone
);

  localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned CW = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               r_state, w_state_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [IW-1:0]        r_idx, w_idx_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic [DATA_BITS-1:0] r_hold, w_hold_n;
  logic                 r_ready, w_ready_n;
  logic                 r_tx, w_tx_n;
  logic                 r_busy, w_busy_n;
  logic                 r_done, w_done_n;
  logic                 w_reload;
  logic                 w_direct;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_hold_n  = r_hold;
    w_ready_n = r_ready;
    w_done_n  = 1'b0;
    w_reload  = 1'b0;
    w_direct  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!r_ready) begin
          w_reload = 1'b1;
        end else if (iStart) begin
          w_direct  = 1'b1;
          w_shift_n = iData;
          w_state_n = S_START;
          w_cnt_n   = '0;
        end
      end
      S_START: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_state_n = S_DATA;
          w_cnt_n   = '0;
          w_idx_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_n = '0;
          if (r_idx == IW'(DATA_BITS - 1)) begin
            w_state_n = S_STOP;
          end else begin
            w_idx_n   = r_idx + 1'b1;
            w_shift_n = r_shift >> 1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == CW'(STOP_CLKS - 1)) begin
          w_done_n  = 1'b1;
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
          if (!r_ready) w_reload = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_reload) begin
      w_shift_n = r_hold;
      w_state_n = S_START;
      w_cnt_n   = '0;
      w_ready_n = 1'b1;
    end

    // The edge that frees the holding register may refill it in the same cycle.
    if (iStart && (r_ready || w_reload) && !w_direct) begin
      w_hold_n  = iData;
      w_ready_n = 1'b0;
    end

    w_busy_n = (w_state_n != S_IDLE);
    unique case (w_state_n)
      S_START: w_tx_n = 1'b0;
      S_DATA:  w_tx_n = w_shift_n[0];
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_hold  <= '0;
      r_ready <= 1'b1;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_hold  <= w_hold_n;
      r_ready <= w_ready_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign oTx    = r_tx;
  assign oBusy  = r_busy;
  assign oReady = r_ready;
  assign oDone  = r_done;

endmodule

// File: tb/tb_serial_out_port.sv
// Bench for serial_out_port: frame-time model (one and two stop bits) checked
// every cycle, plus literal waveform expectations for the directed scenarios.
module tb_serial_out_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       tx1, busy1, ready1, done1;
  logic       tx2, busy2, ready2, done2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_out_port #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .iClk(clk), .iReset(rst), .iData(data), .iStart(start),
    .oTx(tx1), .oBusy(busy1), .oReady(ready1), .oDone(done1));

  serial_out_port #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .iClk(clk), .iReset(rst), .iData(data), .iStart(start),
    .oTx(tx2), .oBusy(busy2), .oReady(ready2), .oDone(done2));

  // Model: a frame is a byte plus elapsed time t within (1+8+S)*4 cycles.
  typedef struct {
    bit         active;
    int         t;
    logic [7:0] fb;
    bit         hfull;
    logic [7:0] hb;
    bit         done;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mstep(mdl_t m, bit r, bit st, logic [7:0] d, int s);
    int   len = (9 + s) * 4;
    bit   reload, direct, acc;
    mdl_t n = m;
    n.done = 1'b0;
    if (r) begin
      n.active = 1'b0;
      n.t      = 0;
      n.hfull  = 1'b0;
      return n;
    end
    reload = m.hfull && (!m.active || m.t == len - 1);
    direct = !m.active && !m.hfull && st;
    acc    = st && (!m.hfull || reload) && !direct;
    if (m.active) begin
      if (m.t == len - 1) begin
        n.done = 1'b1;
        if (m.hfull) begin
          n.fb = m.hb; n.t = 0; n.hfull = 1'b0;
        end else begin
          n.active = 1'b0;
        end
      end else begin
        n.t = m.t + 1;
      end
    end else if (m.hfull) begin
      n.active = 1'b1; n.fb = m.hb; n.t = 0; n.hfull = 1'b0;
    end else if (st) begin
      n.active = 1'b1; n.fb = d; n.t = 0;
    end
    if (acc) begin
      n.hb = d; n.hfull = 1'b1;
    end
    return n;
  endfunction

  function automatic bit mtx(mdl_t m);
    int b;
    if (!m.active) return 1'b1;
    b = m.t / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return m.fb[b-1];
    return 1'b1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, step models at the edge, compare 1 time unit later.
  task automatic tick(input bit r, input bit st, input logic [7:0] d);
    rst = r; start = st; data = d;
    @(posedge clk);
    m1 = mstep(m1, r, st, d, 1);
    m2 = mstep(m2, r, st, d, 2);
    #1;
    chk("tx1",    int'(tx1),    int'(mtx(m1)));
    chk("busy1",  int'(busy1),  int'(m1.active));
    chk("ready1", int'(ready1), int'(!m1.hfull));
    chk("done1",  int'(done1),  int'(m1.done));
    chk("tx2",    int'(tx2),    int'(mtx(m2)));
    chk("busy2",  int'(busy2),  int'(m2.active));
    chk("ready2", int'(ready2), int'(!m2.hfull));
    chk("done2",  int'(done2),  int'(m2.done));
  endtask

  logic h_tx1[0:99], h_busy1[0:99], h_done1[0:99], h_rdy1[0:99];
  logic h_tx2[0:99], h_done2[0:99];

  // Strobe at step 0, then idle; hist[n] holds outputs after edge n.
  task automatic run_frame(input logic [7:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, i == 0, (i == 0) ? d0 : 8'($urandom));
      h_tx1[i] = tx1; h_busy1[i] = busy1; h_done1[i] = done1; h_rdy1[i] = ready1;
      h_tx2[i] = tx2; h_done2[i] = done2;
    end
  endtask

  initial begin
    logic [9:0] exp_a5;
    logic [7:0] b0, b1;
    int cnt, lows;

    m1 = '{default: 0};
    m2 = '{default: 0};
    rst = 1'b1; start = 1'b0; data = '0;

    // Reset
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    chk("rst_tx", int'(tx1), 1);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_ready", int'(ready1), 1);
    chk("rst_done", int'(done1), 0);
    tick(1'b0, 1'b0, 8'h00);

    // Single byte A5
    exp_a5 = 10'b1101001010;
    run_frame(8'hA5, 60);
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < 4; k++)
        chk($sformatf("a5_bit%0d", b), int'(h_tx1[4*b+k]), int'(exp_a5[b]));
    cnt = 0;
    for (int i = 0; i < 60; i++) cnt += int'(h_busy1[i]);
    chk("a5_busy_cycles", cnt, 40);
    chk("a5_done_at", int'(h_done1[40]), 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) cnt += int'(h_done1[i]);
    chk("a5_done_count", cnt, 1);

    // Back-to-back 3C, 81 at step 5, overflow FF at step 6
    for (int i = 0; i < 100; i++) begin
      if (i == 0)      tick(1'b0, 1'b1, 8'h3C);
      else if (i == 5) tick(1'b0, 1'b1, 8'h81);
      else if (i == 6) tick(1'b0, 1'b1, 8'hFF);
      else             tick(1'b0, 1'b0, 8'h55);
      h_tx1[i] = tx1; h_busy1[i] = busy1; h_done1[i] = done1; h_rdy1[i] = ready1;
    end
    chk("b2b_ready_low", int'(h_rdy1[5]), 0);
    chk("b2b_ready_before", int'(h_rdy1[4]), 1);
    chk("b2b_stop1", int'(h_tx1[39]), 1);
    chk("b2b_start2", int'(h_tx1[40]), 0);
    chk("b2b_ready_back", int'(h_rdy1[40]), 1);
    b0 = '0; b1 = '0;
    for (int b = 0; b < 8; b++) begin
      b0[b] = h_tx1[4*(b+1)+1];
      b1[b] = h_tx1[40 + 4*(b+1)+1];
    end
    chk("b2b_byte0", int'(b0), 'h3C);
    chk("b2b_byte1", int'(b1), 'h81);
    cnt = 0;
    for (int i = 0; i < 100; i++) cnt += int'(h_busy1[i]);
    chk("b2b_busy_cycles", cnt, 80);
    cnt = 0;
    for (int i = 0; i < 100; i++) cnt += int'(h_done1[i]);
    chk("b2b_done_count", cnt, 2);
    chk("b2b_done2_at", int'(h_done1[80]), 1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'h00);

    // Reset mid-frame at step 18 of an 00 frame
    for (int i = 0; i < 60; i++) begin
      tick(i == 18, i == 0, 8'h00);
      h_tx1[i] = tx1; h_busy1[i] = busy1; h_done1[i] = done1;
    end
    chk("mid_pre_tx", int'(h_tx1[17]), 0);
    chk("mid_rst_tx", int'(h_tx1[18]), 1);
    chk("mid_rst_busy", int'(h_busy1[18]), 0);
    cnt = 0;
    for (int i = 0; i < 60; i++) cnt += int'(h_done1[i]);
    chk("mid_no_done", cnt, 0);
    run_frame(8'h5A, 60);
    chk("mid_clean_done", int'(h_done1[40]), 1);

    // Two stop bits with FF (second instance)
    run_frame(8'hFF, 60);
    lows = 0;
    for (int i = 0; i < 44; i++) lows += int'(!h_tx2[i]);
    chk("s2_low_cycles", lows, 4);
    chk("s2_low_first", int'(h_tx2[3]), 0);
    chk("s2_high_after", int'(h_tx2[4]), 1);
    chk("s2_done_at", int'(h_done2[44]), 1);
    chk("s2_no_early_done", int'(h_done2[40]), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 5) == 0), 8'($urandom));
    end
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
